// File: rtl/irq_dispatch_4.sv
// irq_dispatch_4: 4-line edge-capturing interrupt dispatcher with an
// offer/ack handshake, fixed priority (3 highest) and an offer timeout.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   req, mask   level request lines and dispatch-block mask
//   irq_valid   an offer is live
//   irq_id      offered line index
//   irq_ack     consumer accepts the offer
//   pending     captured events
//   timeout     one-cycle pulse when an offer is withdrawn
module irq_dispatch_4 #(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ack,
  output logic [3:0] pending,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam logic [3:0] CNT_LAST =
    4'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [3:0] req_q;
  logic [3:0] cnt;
  logic [3:0] ev;
  logic [3:0] clr;
  logic [3:0] cand;
  logic [1:0] top;
  logic       take;

  assign ev   = req & ~req_q;
  assign take = irq_valid & irq_ack;
  assign cand = pending & ~mask;

  always_comb begin
    clr = '0;
    if (take) begin
      unique case (irq_id)
        2'd0: clr = 4'b0001;
        2'd1: clr = 4'b0010;
        2'd2: clr = 4'b0100;
        2'd3: clr = 4'b1000;
        default: clr = '0;
      endcase
    end
  end

  always_comb begin
    top = 2'd0;
    if (cand[3])      top = 2'd3;
    else if (cand[2]) top = 2'd2;
    else if (cand[1]) top = 2'd1;
    else              top = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      timeout   <= 1'b0;
      cnt       <= '0;
    end else begin
      req_q   <= req;
      // new events override an ack clear of the same bit
      pending <= (pending & ~clr) | ev;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|cand) begin
            state     <= OFFER;
            irq_id    <= top;
            irq_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch_4.sv
// tb_irq_dispatch_4: vector table, directed corner sequences and a
// random run against a behavioural model of the dispatcher.
module tb_irq_dispatch_4;

  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] pending;
  logic       timeout;

  int total;
  int bad;

  irq_dispatch_4 #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .pending  (pending),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] m;
    logic       a;
    logic [3:0] ep;
    logic       ev;
    logic [1:0] eid;
    logic       eto;
  } vec_t;

  vec_t tbl [25];

  // behavioural model state
  bit mp    [4];
  bit mprev [4];
  int moff;
  int mage;
  bit mto;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r,
                      input logic [3:0] m,
                      input logic       a);
    req     = r;
    mask    = m;
    irq_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm,
                         input logic [3:0] ep,
                         input logic ev,
                         input logic [1:0] eid,
                         input logic eto);
    chk({nm, ".pend"}, int'(pending), int'(ep));
    chk({nm, ".valid"}, int'(irq_valid), int'(ev));
    if (ev) chk({nm, ".id"}, int'(irq_id), int'(eid));
    chk({nm, ".tmo"}, int'(timeout), int'(eto));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mp[i]    = 1'b0;
      mprev[i] = 1'b0;
    end
    moff = -1;
    mage = 0;
    mto  = 1'b0;
  endtask

  // one clock edge of the dispatcher, from its rules
  task automatic model_step(input logic [3:0] r,
                            input logic [3:0] m,
                            input logic       a);
    bit np [4];
    bit acked;
    int hi;
    acked = (moff >= 0) && a;
    for (int i = 0; i < 4; i++)
      np[i] = (r[i] && !mprev[i]) ||
              (mp[i] && !(acked && moff == i));
    mto = 1'b0;
    if (moff < 0) begin
      hi = -1;
      for (int i = 0; i < 4; i++)
        if (mp[i] && !m[i]) hi = i;
      if (hi >= 0) begin
        moff = hi;
        mage = 1;
      end
    end else if (a) begin
      moff = -1;
    end else if (mage == TO) begin
      moff = -1;
      mto  = 1'b1;
    end else begin
      mage++;
    end
    for (int i = 0; i < 4; i++) begin
      mp[i]    = np[i];
      mprev[i] = r[i];
    end
  endtask

  initial begin
    logic [3:0] pk;
    logic [3:0] r;
    logic [3:0] m;
    logic       a;
    int         ackw;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    irq_ack = 1'b0;

    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{4'b0101, 4'b0000, 1'b0, 4'b0101, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0000, 1'b0, 4'b0101, 1'b1, 2'd2, 1'b0};
    tbl[6]  = '{4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 1'b0, 4'b1001, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b1001, 4'b1000, 1'b0, 4'b1001, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[18] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[19] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[20] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[21] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[22] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[23] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[24] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    // reset state
    #12;
    chk("rst.pend", int'(pending), 0);
    chk("rst.valid", int'(irq_valid), 0);
    chk("rst.id", int'(irq_id), 0);
    chk("rst.tmo", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r, tbl[i].m, tbl[i].a);
      chk_out($sformatf("vec%0d", i), tbl[i].ep,
              tbl[i].ev, tbl[i].eid, tbl[i].eto);
    end

    // timeout and re-offer
    step(4'b0010, 4'b0000, 1'b0);
    chk_out("to.cap", 4'b0010, 1'b0, 2'd0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(4'b0000, 4'b0000, 1'b0);
      chk_out($sformatf("to.off%0d", k),
              4'b0010, 1'b1, 2'd1, 1'b0);
    end
    step(4'b0000, 4'b0000, 1'b0);
    chk_out("to.pulse", 4'b0010, 1'b0, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    chk_out("to.reoff", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int k = 2; k <= TO; k++) begin
      step(4'b0000, 4'b0000, 1'b0);
      chk_out($sformatf("to.hold%0d", k),
              4'b0010, 1'b1, 2'd1, 1'b0);
    end
    // ack on the timeout edge wins
    step(4'b0000, 4'b0000, 1'b1);
    chk_out("to.ackwin", 4'b0000, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    chk_out("to.after", 4'b0000, 1'b0, 2'd0, 1'b0);

    // reset mid-offer, req[3] held through release
    step(4'b0010, 4'b0010, 1'b0);
    step(4'b1000, 4'b0010, 1'b0);
    chk_out("rm.cap", 4'b1010, 1'b0, 2'd0, 1'b0);
    step(4'b1000, 4'b0010, 1'b0);
    chk_out("rm.off", 4'b1010, 1'b1, 2'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("rm.async", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("rm.id0", int'(irq_id), 0);
    @(posedge clk);
    #1;
    chk_out("rm.held", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 4'b0000, 1'b0);
    chk_out("rm.ev", 4'b1000, 1'b0, 2'd0, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    chk_out("rm.off3", 4'b1000, 1'b1, 2'd3, 1'b0);
    step(4'b1000, 4'b0000, 1'b1);
    chk_out("rm.ack", 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'b1000, 4'b0000, 1'b0);
      chk_out($sformatf("rm.once%0d", k),
              4'b0000, 1'b0, 2'd0, 1'b0);
    end

    // random run against the model
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    mask  = '0;
    irq_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ackw = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) ackw = $urandom_range(1, 12);
      r = 4'($urandom);
      if ($urandom_range(0, 1) == 0) r = req;
      m = ($urandom_range(0, 3) == 0) ?
          4'($urandom) : 4'b0000;
      a = ($urandom_range(1, ackw) == 1);
      step(r, m, a);
      model_step(r, m, a);
      for (int i = 0; i < 4; i++) pk[i] = mp[i];
      chk("rnd.pend", int'(pending), int'(pk));
      chk("rnd.valid", int'(irq_valid),
          (moff >= 0) ? 1 : 0);
      if (moff >= 0)
        chk("rnd.id", int'(irq_id), moff);
      chk("rnd.tmo", int'(timeout), int'(mto));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
